// File: rtl/my_pipe_chain.sv
// DEPTH-stage valid/ready register pipeline; stage 0 applies a MODE-selected bitwise
// transform, later stages carry data unchanged. Supports backpressure, flush and occupancy.
module my_pipe_chain #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MODE  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] rdy;

    function automatic logic [WIDTH-1:0] stage0_op(input logic [WIDTH-1:0] x);
        case (MODE)
            1:       return ~x;
            2:       return x ^ (x >> 1);
            default: return x;
        endcase
    endfunction

    // Readiness ripples from the output back: a stage can load if any stage at or
    // beyond it is empty, or the downstream is taking the last word.
    always_comb begin : ready_chain
        logic acc;
        rdy = '0;
        acc = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            acc = acc | ~v[DEPTH-1-k];
            rdy[DEPTH-1-k] = acc;
        end
    end

    assign in_ready = rdy[0] & ~flush & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                d[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= stage0_op(in_data);
                end
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    d[i] <= d[i-1];
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule
